wb_reg_bridge: RTL and testbench



---
 rtl/usbh_wb_pkg.sv | 23 ++
 rtl/wb_reg_bridge_cnt.sv | 26 ++
 rtl/wb_reg_bridge.sv | 145 ++++++++++++++
 tb/tb_wb_reg_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/usbh_wb_pkg.sv
// Shared definitions for the Wishbone register bridge family.
package usbh_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RECOVER = 2'd2
  } state_e;

  localparam int DEF_AW       = 8;
  localparam int DEF_DW       = 32;
  localparam int DEF_ACK_LAT  = 1;
  localparam int DEF_RECOVERY = 3;
  localparam int DEF_TIMEOUT  = 0;

  // Read data returned alongside wb_err_o (replicated to DW bits).
  localparam logic ERR_BIT = 1'b0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_reg_bridge_cnt.sv
// Wait counter: cleared while idle, counts strobe + WAIT cycles, saturates.
module wb_reg_bridge_cnt #(
  parameter int ACK_LAT = 1,
  parameter int TIMEOUT = 0,
  parameter int CW      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic lat_ok,
  output logic to_hit
);

  logic [CW-1:0] cnt;

  // Count while the transfer is live, hold at all-ones, clear otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (!run)  cnt <= '0;
    else if (~&cnt) cnt <= cnt + 1'b1;
  end

  assign lat_ok = (cnt >= CW'(ACK_LAT - 1));
  assign to_hit = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_reg_bridge.sv
// Wishbone classic slave to single-cycle register strobes, with ack
// latency, slave ready handshake, recovery gap, timeout and abort.
module wb_reg_bridge
  import usbh_wb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int SW       = DW / 8,
  parameter int ACK_LAT  = DEF_ACK_LAT,
  parameter int RECOVERY = DEF_RECOVERY,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [DW-1:0] wb_dat_i,
  output logic [DW-1:0] wb_dat_o,
  input  logic          wb_we_i,
  input  logic          wb_stb_i,
  input  logic          wb_cyc_i,
  input  logic [SW-1:0] wb_sel_i,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_wr_o,
  output logic [SW-1:0] be_o,
  output logic          we_o,
  output logic          re_o,
  input  logic [DW-1:0] dat_rd_i,
  input  logic          rdy_i
);

  localparam int CW = $clog2(max2(ACK_LAT, TIMEOUT) + 1) + 1;
  localparam int RW = $clog2(RECOVERY + 1);

  state_e        state;
  logic [AW-1:0] adr_s;
  logic [DW-1:0] dat_s;
  logic [SW-1:0] sel_s;
  logic          we_s, cyc_s, stb_s;
  logic          rdy_seen;
  logic [DW-1:0] rd_buf;
  logic [RW-1:0] rec_cnt;
  logic          strobe, done, lat_ok, to_hit, rdy_any;

  // Register the bus inputs every cycle.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      adr_s <= '0;
      dat_s <= '0;
      sel_s <= '0;
      we_s  <= 1'b0;
      cyc_s <= 1'b0;
      stb_s <= 1'b0;
    end else begin
      adr_s <= wb_adr_i;
      dat_s <= wb_dat_i;
      sel_s <= wb_sel_i;
      we_s  <= wb_we_i;
      cyc_s <= wb_cyc_i;
      stb_s <= wb_stb_i;
    end
  end

  assign adr_o    = adr_s;
  assign dat_wr_o = dat_s;
  assign be_o     = sel_s;

  assign strobe  = (state == IDLE) && stb_s && cyc_s;
  assign rdy_any = rdy_i || rdy_seen;
  assign done    = (strobe || (state == WAIT)) && lat_ok && rdy_any;
  assign we_o    = strobe && we_s && (|sel_s);
  assign re_o    = strobe && !we_s;

  // Counter runs from the strobe edge through WAIT; RECOVER clears it.
  wb_reg_bridge_cnt #(
    .ACK_LAT (ACK_LAT),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (wb_rst_ni),
    .run    (strobe || (state == WAIT)),
    .lat_ok (lat_ok),
    .to_hit (to_hit)
  );

  // Transfer FSM with registered ack/err/read data.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      rdy_seen <= 1'b0;
      rd_buf   <= '0;
      rec_cnt  <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe) begin
            if (done) begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= dat_rd_i;
              state    <= RECOVER;
              rec_cnt  <= RW'(RECOVERY - 1);
            end else begin
              state <= WAIT;
              if (rdy_i) begin
                rdy_seen <= 1'b1;
                rd_buf   <= dat_rd_i;
              end
            end
          end
        end
        WAIT: begin
          if (!cyc_s || done || (to_hit && !rdy_any)) begin
            // Abort leaves silently; otherwise exactly one of ack/err.
            if (cyc_s && done) begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= rdy_i ? dat_rd_i : rd_buf;
            end else if (cyc_s) begin
              wb_err_o <= 1'b1;
              wb_dat_o <= {DW{ERR_BIT}};
            end
            rdy_seen <= 1'b0;
            state    <= RECOVER;
            rec_cnt  <= RW'(RECOVERY - 1);
          end else if (rdy_i && !rdy_seen) begin
            rdy_seen <= 1'b1;
            rd_buf   <= dat_rd_i;
          end
        end
        RECOVER: begin
          if (rec_cnt == '0) state <= IDLE;
          else               rec_cnt <= rec_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_reg_bridge.sv
// Bench for wb_reg_bridge: per-cycle vector table on a default instance,
// hand sequences on a long-latency/timeout instance.
module tb_wb_reg_bridge;

  typedef struct packed {
    logic        rst_n, cyc, stb, we;
    logic [7:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        rdy;
    logic [31:0] drd;
  } in_t;

  typedef struct packed {
    logic [3:0]  ctl;   // {ack, err, re, we}
    logic        cd;
    logic [31:0] dat;
    logic        ca;
    logic [7:0]  adr;
    logic [3:0]  be;
    logic [31:0] dwr;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t da, db;
  int  checks = 0;
  int  errors = 0;
  vec_t vecs[$];

  logic [31:0] a_dat, a_dwr, b_dat, b_dwr;
  logic [7:0]  a_adr, b_adr;
  logic [3:0]  a_be, b_be;
  logic        a_ack, a_err, a_we, a_re, b_ack, b_err, b_we, b_re;

  wb_reg_bridge #(.ACK_LAT(1), .RECOVERY(3), .TIMEOUT(0)) dut_a (
    .clk(clk), .wb_rst_ni(da.rst_n), .wb_adr_i(da.adr), .wb_dat_i(da.dat),
    .wb_dat_o(a_dat), .wb_we_i(da.we), .wb_stb_i(da.stb), .wb_cyc_i(da.cyc),
    .wb_sel_i(da.sel), .wb_ack_o(a_ack), .wb_err_o(a_err), .adr_o(a_adr),
    .dat_wr_o(a_dwr), .be_o(a_be), .we_o(a_we), .re_o(a_re),
    .dat_rd_i(da.drd), .rdy_i(da.rdy)
  );

  wb_reg_bridge #(.ACK_LAT(4), .RECOVERY(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .wb_rst_ni(db.rst_n), .wb_adr_i(db.adr), .wb_dat_i(db.dat),
    .wb_dat_o(b_dat), .wb_we_i(db.we), .wb_stb_i(db.stb), .wb_cyc_i(db.cyc),
    .wb_sel_i(db.sel), .wb_ack_o(b_ack), .wb_err_o(b_err), .adr_o(b_adr),
    .dat_wr_o(b_dwr), .be_o(b_be), .we_o(b_we), .re_o(b_re),
    .dat_rd_i(db.drd), .rdy_i(db.rdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t rq(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic rdy, input logic [31:0] drd);
    in_t r;
    r.rst_n = 1'b1; r.cyc = 1'b1; r.stb = 1'b1; r.we = we; r.adr = adr;
    r.dat = dat; r.sel = sel; r.rdy = rdy; r.drd = drd;
    return r;
  endfunction

  function automatic in_t idl(input logic rdy);
    in_t r;
    r = '0; r.rst_n = 1'b1; r.rdy = rdy;
    return r;
  endfunction

  function automatic in_t rs();
    in_t r;
    r = '0; r.rdy = 1'b1;
    return r;
  endfunction

  task automatic add(input in_t i, input logic [3:0] ctl);
    vec_t v;
    v.i = i; v.e = '0; v.e.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic add_d(input in_t i, input logic [3:0] ctl, input logic [31:0] dat);
    vec_t v;
    v.i = i; v.e = '0; v.e.ctl = ctl; v.e.cd = 1'b1; v.e.dat = dat;
    vecs.push_back(v);
  endtask

  task automatic add_a(input in_t i, input logic [3:0] ctl, input logic [7:0] adr,
                       input logic [3:0] be, input logic [31:0] dwr);
    vec_t v;
    v.i = i; v.e = '0; v.e.ctl = ctl; v.e.ca = 1'b1;
    v.e.adr = adr; v.e.be = be; v.e.dwr = dwr;
    vecs.push_back(v);
  endtask

  // One transfer on dut_b. mode 0: rdy never; 1: rdy only in strobe cycle;
  // 2: rdy held high. Watches a fixed window for ack/err pulses.
  task automatic b_xfer(input logic [7:0] adr, input logic [31:0] drd, input int mode,
                        output int lat, output int nack, output int nerr,
                        output logic [31:0] dato);
    @(posedge clk); #1;
    db = rq(1'b0, adr, 32'h0, 4'hf, 1'b0, 32'h0);
    @(posedge clk); #1;
    db.rdy = (mode != 0); db.drd = drd;
    @(negedge clk);
    chk($sformatf("b_re adr %h", adr), 64'(b_re), 64'd1);
    lat = -1; nack = 0; nerr = 0; dato = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      db.rdy = (mode == 2);
      if (mode != 2) db.drd = 32'h0;
      if (lat >= 0) begin db.cyc = 1'b0; db.stb = 1'b0; end
      @(negedge clk);
      if ((b_ack || b_err) && lat < 0) begin lat = k; dato = b_dat; end
      nack += int'(b_ack);
      nerr += int'(b_err);
    end
  endtask

  initial begin
    in_t q1, q2, w1, w0, a1, a2, t1, tr, c;
    int lat, nack, nerr;
    logic [31:0] dato;

    da = rs();
    db = rs();

    q1 = rq(1'b0, 8'h10, 32'h0, 4'hf, 1'b1, 32'hCAFEF00D);
    q2 = rq(1'b0, 8'h14, 32'h0, 4'hf, 1'b1, 32'h0BADBEEF);
    w1 = rq(1'b1, 8'h04, 32'h12345678, 4'b0011, 1'b1, 32'h0);
    w0 = rq(1'b1, 8'h08, 32'hFFFF0000, 4'b0000, 1'b1, 32'h0);
    a1 = rq(1'b0, 8'h20, 32'h0, 4'hf, 1'b0, 32'h0);
    a2 = rq(1'b0, 8'h24, 32'h0, 4'hf, 1'b1, 32'h11223344);
    t1 = rq(1'b0, 8'h30, 32'h0, 4'hf, 1'b0, 32'h0);
    tr = t1; tr.rst_n = 1'b0;
    c  = rq(1'b0, 8'h34, 32'h0, 4'hf, 1'b1, 32'h55AA55AA);

    // reset state
    add_d(rs(), 4'b0000, 32'h0);
    add_a(rs(), 4'b0000, 8'h0, 4'h0, 32'h0);
    add(idl(1'b1), 4'b0000);
    // read, ack after two edges, back-to-back read accepted after recovery
    add(q1, 4'b0000);
    add_a(q1, 4'b0010, 8'h10, 4'hf, 32'h0);
    add_d(q1, 4'b1000, 32'hCAFEF00D);
    add(q2, 4'b0000);
    add_d(q2, 4'b0000, 32'hCAFEF00D);
    add_a(q2, 4'b0010, 8'h14, 4'hf, 32'h0);
    add_d(q2, 4'b1000, 32'h0BADBEEF);
    // write with partial selects, then write with no selects
    add(w1, 4'b0000);
    add(w1, 4'b0000);
    add_a(w1, 4'b0001, 8'h04, 4'b0011, 32'h12345678);
    add(w1, 4'b1000);
    add(w0, 4'b0000);
    add(w0, 4'b0000);
    add_a(w0, 4'b0000, 8'h08, 4'b0000, 32'hFFFF0000);
    add(w0, 4'b1000);
    add(idl(1'b1), 4'b0000);
    add(idl(1'b1), 4'b0000);
    add_d(idl(1'b1), 4'b0000, 32'h0);
    // abort: cyc dropped while waiting for rdy
    add(a1, 4'b0000);
    add(a1, 4'b0010);
    add(a1, 4'b0000);
    add(idl(1'b0), 4'b0000);
    add(idl(1'b0), 4'b0000);
    add(idl(1'b1), 4'b0000);
    add(a2, 4'b0000);
    add(a2, 4'b0000);
    add_a(a2, 4'b0010, 8'h24, 4'hf, 32'h0);
    add_d(a2, 4'b1000, 32'h11223344);
    // reset while in WAIT
    add(idl(1'b1), 4'b0000);
    add(idl(1'b1), 4'b0000);
    add(t1, 4'b0000);
    add(t1, 4'b0010);
    add(t1, 4'b0000);
    add_d(tr, 4'b0000, 32'h0);
    add_a(idl(1'b1), 4'b0000, 8'h0, 4'h0, 32'h0);
    add(idl(1'b1), 4'b0000);
    add(c, 4'b0000);
    add_a(c, 4'b0010, 8'h34, 4'hf, 32'h0);
    add_d(c, 4'b1000, 32'h55AA55AA);
    add(idl(1'b1), 4'b0000);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      da = vecs[i].i.rst_n ? vecs[i].i : vecs[i].i;
      @(negedge clk);
      chk($sformatf("row%0d ctl", i), 64'({a_ack, a_err, a_re, a_we}), 64'(vecs[i].e.ctl));
      if (vecs[i].e.cd)
        chk($sformatf("row%0d dat_o", i), 64'(a_dat), 64'(vecs[i].e.dat));
      if (vecs[i].e.ca)
        chk($sformatf("row%0d adr/be/dwr", i), {20'h0, a_adr, a_be, a_dwr},
            {20'h0, vecs[i].e.adr, vecs[i].e.be, vecs[i].e.dwr});
    end

    // Long-latency instance out of reset.
    @(posedge clk); #1;
    db = idl(1'b1);
    repeat (2) @(posedge clk);

    // rdy only in the strobe cycle: held, ack four cycles later
    b_xfer(8'h40, 32'hA5A5A5A5, 1, lat, nack, nerr, dato);
    chk("b_hold lat", 64'(lat), 64'd4);
    chk("b_hold nack", 64'(nack), 64'd1);
    chk("b_hold nerr", 64'(nerr), 64'd0);
    chk("b_hold dat", 64'(dato), 64'hA5A5A5A5);

    // rdy never: err at cnt=7, read data forced to zero
    b_xfer(8'h44, 32'h0, 0, lat, nack, nerr, dato);
    chk("b_to lat", 64'(lat), 64'd8);
    chk("b_to nack", 64'(nack), 64'd0);
    chk("b_to nerr", 64'(nerr), 64'd1);
    chk("b_to dat", 64'(dato), 64'h0);

    // next request with rdy held acks normally
    b_xfer(8'h48, 32'h600DF00D, 2, lat, nack, nerr, dato);
    chk("b_ok lat", 64'(lat), 64'd4);
    chk("b_ok nack", 64'(nack), 64'd1);
    chk("b_ok nerr", 64'(nerr), 64'd0);
    chk("b_ok dat", 64'(dato), 64'h600DF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
